// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the core's data-memory port.
// Stores to DATA fill a TX FIFO; loads return STATUS and the baud divisor combinationally.
module mmio_uart_tx #(
  parameter int          CLOCK_FREQ   = 25000000,
  parameter int          BAUD_RATE    = 115200,
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [31:0] BASE_ADDRESS = 32'h00001000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memory_read,
  input  logic        memory_write,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        tx,
  output logic        irq,
  output logic [1:0]  state_dbg
);

  localparam int          PW        = $clog2(FIFO_DEPTH);
  localparam int          CW        = PW + 1;
  localparam logic [15:0] RESET_DIV = 16'(CLOCK_FREQ / BAUD_RATE);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state;
  logic [7:0]      fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            overflow;
  logic [15:0]     div_reg;
  logic [15:0]     act_div;
  logic [15:0]     baud_cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      shift;
  logic            tx_r;

  logic            sel;
  logic [1:0]      offset;
  logic            push_req;
  logic            clr_req;
  logic            div_we;
  logic            fifo_empty;
  logic            fifo_full;
  logic            bit_end;
  logic            pop;
  logic            accept;
  logic            busy;

  assign sel        = (address[31:4] == BASE_ADDRESS[31:4]);
  assign offset     = address[3:2];
  assign push_req   = sel && memory_write && (offset == 2'd0);
  assign clr_req    = sel && memory_write && (offset == 2'd1) && write_data[4];
  assign div_we     = sel && memory_write && (offset == 2'd2);
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CW'(FIFO_DEPTH));
  assign bit_end    = (baud_cnt == act_div - 16'd1);
  // A pop either starts from IDLE or chains straight out of a finishing stop bit.
  assign pop        = !fifo_empty && ((state == IDLE) || ((state == STOP) && bit_end));
  assign accept     = push_req && (!fifo_full || pop);
  assign busy       = (state != IDLE);

  assign tx        = tx_r;
  assign irq       = fifo_empty && (state == IDLE);
  assign state_dbg = state;

  always_comb begin
    read_data = 32'd0;
    if (sel && memory_read) begin
      case (offset)
        2'd1:    read_data = {27'd0, overflow, fifo_empty, fifo_full, busy, 1'b0};
        2'd2:    read_data = {16'd0, div_reg};
        default: read_data = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) fifo_mem[wr_ptr] <= write_data[7:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      div_reg  <= RESET_DIV;
    end else begin
      if (accept) wr_ptr <= wr_ptr + PW'(1);
      if (pop)    rd_ptr <= rd_ptr + PW'(1);
      case ({accept, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // Set beats clear when both land on the same edge.
      if (push_req && fifo_full && !pop) overflow <= 1'b1;
      else if (clr_req)                  overflow <= 1'b0;
      if (div_we) div_reg <= (write_data[15:0] < 16'd2) ? 16'd2 : write_data[15:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      tx_r     <= 1'b1;
      shift    <= 8'd0;
      bit_cnt  <= 3'd0;
      baud_cnt <= 16'd0;
      act_div  <= RESET_DIV;
    end else begin
      case (state)
        IDLE: begin
          tx_r     <= 1'b1;
          baud_cnt <= 16'd0;
          if (pop) begin
            shift   <= fifo_mem[rd_ptr];
            act_div <= div_reg;
            tx_r    <= 1'b0;
            state   <= START;
          end
        end
        START: begin
          if (bit_end) begin
            baud_cnt <= 16'd0;
            bit_cnt  <= 3'd0;
            tx_r     <= shift[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_cnt <= 16'd0;
            if (bit_cnt == 3'd7) begin
              tx_r  <= 1'b1;
              state <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              shift   <= {1'b0, shift[7:1]};
              tx_r    <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        STOP: begin
          if (bit_end) begin
            baud_cnt <= 16'd0;
            if (pop) begin
              shift   <= fifo_mem[rd_ptr];
              act_div <= div_reg;
              tx_r    <= 1'b0;
              state   <= START;
            end else begin
              tx_r  <= 1'b1;
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Randomised scoreboard bench for mmio_uart_tx: a line monitor decodes frames
// and checks them against bytes and divisors predicted from the register rules.
module tb_mmio_uart_tx;

  localparam int          DEPTH  = 8;
  localparam logic [31:0] A_DATA = 32'h0000_1000;
  localparam logic [31:0] A_STAT = 32'h0000_1004;
  localparam logic [31:0] A_DIV  = 32'h0000_1008;
  localparam logic [31:0] A_RSV  = 32'h0000_100C;

  logic        clk;
  logic        rst_n;
  logic        memory_read;
  logic        memory_write;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        tx;
  logic        irq;
  logic [1:0]  state_dbg;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model state.
  logic [7:0]  exp_q[$];
  int          pushed         = 0;
  int          frames_started = 0;
  int          frames_done    = 0;
  int          model_div      = 10;
  logic        model_ovf      = 1'b0;
  int          last_start     = 0;
  int          last_end       = 0;
  logic        in_frame       = 1'b0;
  logic        expect_next    = 1'b0;

  mmio_uart_tx #(
    .CLOCK_FREQ  (1000000),
    .BAUD_RATE   (100000),
    .FIFO_DEPTH  (DEPTH),
    .BASE_ADDRESS(32'h0000_1000)
  ) dut (
    .clk         (clk),
    .reset       (rst_n),
    .memory_read (memory_read),
    .memory_write(memory_write),
    .address     (address),
    .write_data  (write_data),
    .read_data   (read_data),
    .tx          (tx),
    .irq         (irq),
    .state_dbg   (state_dbg)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #900000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int model_occ();
    return pushed - frames_started;
  endfunction

  // Driver tasks: inputs change 1 time unit after a rising edge.
  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    logic acc;
    logic is_data;
    is_data = (addr[31:4] == A_DATA[31:4]) && (addr[3:2] == 2'd0);
    acc = model_occ() < DEPTH;
    memory_write = 1'b1;
    address      = addr;
    write_data   = data;
    @(posedge clk);
    #1;
    if (is_data) begin
      if (acc) begin
        exp_q.push_back(data[7:0]);
        pushed++;
      end else begin
        model_ovf = 1'b1;
      end
    end
    if (addr == A_DIV) model_div = (data[15:0] < 16'd2) ? 2 : int'(data[15:0]);
    if (addr == A_STAT && data[4] && !(is_data && !acc)) model_ovf = 1'b0;
    memory_write = 1'b0;
    address      = 32'h0;
    write_data   = 32'h0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    memory_read = 1'b1;
    address     = addr;
    #1;
    data        = read_data;
    memory_read = 1'b0;
    address     = 32'h0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (!((frames_done == pushed) && !in_frame) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("wait_idle_timeout", (n < budget), 1'b1);
    @(posedge clk);
    #1;
  endtask

  // Monitor: decodes every frame on tx against the head of the expected queue.
  task automatic run_frame();
    logic [7:0] exp_byte;
    int         d;
    logic       exp_bit;
    logic       ok;
    frames_started++;
    last_start = cyc;
    in_frame   = 1'b1;
    check("frame_expected", (exp_q.size() != 0), 1'b1);
    exp_byte = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
    d = model_div;
    for (int b = 0; b < 10; b++) begin
      exp_bit = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : exp_byte[b-1];
      ok = 1'b1;
      for (int s = 0; s < d; s++) begin
        if (b > 0 || s > 0) @(negedge clk);
        if (!rst_n) begin
          in_frame = 1'b0;
          return;
        end
        if (tx !== exp_bit) ok = 1'b0;
      end
      check($sformatf("frame_bit%0d_byte%02h", b, exp_byte), ok, 1'b1);
    end
    last_end    = cyc;
    expect_next = (pushed - frames_started) > 0;
    frames_done++;
    in_frame = 1'b0;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (expect_next && rst_n) check("no_gap_between_frames", tx, 1'b0);
      expect_next = 1'b0;
      if (rst_n && tx === 1'b0) run_frame();
    end
  end

  // Stimulus
  initial begin
    logic [31:0] rd;
    int          t0;
    int          nlow;
    int          fs;
    int          n;
    rst_n        = 1'b0;
    memory_read  = 1'b0;
    memory_write = 1'b0;
    address      = 32'h0;
    write_data   = 32'h0;

    repeat (3) @(negedge clk);
    check("reset_tx", tx, 1'b1);
    check("reset_irq", irq, 1'b1);
    bus_read(A_STAT, rd); check("reset_status", rd, 32'h08);
    bus_read(A_DIV, rd);  check("reset_div", rd, 32'd10);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle_cycles(5);
    check("post_reset_tx", tx, 1'b1);
    check("post_reset_irq", irq, 1'b1);
    bus_read(A_STAT, rd); check("post_reset_status", rd, 32'h08);
    bus_read(A_DIV, rd);  check("post_reset_div", rd, 32'd10);
    bus_read(A_DATA, rd); check("data_reads_zero", rd, 32'h0);

    // Single byte: start bit begins the edge after the store.
    bus_write(A_DATA, 32'h55);
    t0 = cyc;
    idle_cycles(20);
    bus_read(A_STAT, rd); check("busy_mid_frame", rd, 32'h0A);
    check("irq_mid_frame", irq, 1'b0);
    wait_idle(400);
    check("single_start_latency", last_start, t0 + 1);
    check("single_frame_end", last_end, t0 + 100);
    check("irq_after_frame", irq, 1'b1);
    bus_read(A_STAT, rd); check("status_after_frame", rd, 32'h08);

    // Back-to-back frames without an idle gap.
    bus_write(A_DATA, 32'hA5);
    t0 = cyc;
    bus_write(A_DATA, 32'h3C);
    wait_idle(600);
    check("back_to_back_length", last_end - t0, 200);

    // Overflow: ten stores in ten consecutive cycles.
    for (int i = 0; i < 10; i++) bus_write(A_DATA, 32'($urandom_range(0, 255)));
    bus_read(A_STAT, rd);
    check("overflow_status", rd,
          {27'd0, model_ovf, 1'b0, (model_occ() == DEPTH), 1'b1, 1'b0});
    check("overflow_model_drop", model_ovf, 1'b1);
    bus_write(A_STAT, 32'h10);
    bus_read(A_STAT, rd); check("overflow_cleared", rd[4], model_ovf);
    wait_idle(1200);
    check("overflow_accepted_count", frames_done, 12);

    // Divisor: 0 is stored as 2; mid-frame change applies from the next pop.
    bus_write(A_DIV, 32'h0);
    bus_read(A_DIV, rd); check("div_zero_reads_two", rd, 32'd2);
    bus_write(A_DATA, 32'($urandom_range(0, 255)));
    t0 = cyc;
    wait_idle(100);
    check("div2_frame_length", last_end - t0, 20);
    bus_write(A_DIV, 32'd10);
    bus_write(A_DATA, 32'($urandom_range(0, 255)));
    bus_write(A_DATA, 32'($urandom_range(0, 255)));
    idle_cycles(30);
    bus_write(A_DIV, 32'd20);
    bus_read(A_DIV, rd); check("div_reads_20", rd, 32'd20);
    wait_idle(600);
    bus_write(A_DIV, 32'd1);
    bus_read(A_DIV, rd); check("div_one_reads_two", rd, 32'd2);

    // Unselected and reserved accesses do nothing.
    fs = frames_started;
    bus_write(A_RSV, 32'hFF);
    bus_write(32'h0000_2000, 32'h77);
    bus_write(32'h0001_1000, 32'h77);
    bus_read(A_RSV, rd); check("reserved_reads_zero", rd, 32'h0);
    bus_read(32'h0000_2004, rd); check("unselected_reads_zero", rd, 32'h0);
    idle_cycles(20);
    check("unselected_no_frame", frames_started, fs);

    // Random bursts with random divisors.
    for (int r = 0; r < 6; r++) begin
      bus_write(A_DIV, 32'($urandom_range(0, 12)));
      n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) begin
        if (model_occ() < DEPTH - 2) bus_write(A_DATA, 32'($urandom));
        idle_cycles($urandom_range(0, 3));
      end
      wait_idle(1000);
    end
    bus_read(A_STAT, rd); check("random_final_status", rd, 32'h08);

    // Asynchronous reset in the middle of a frame with bytes queued.
    bus_write(A_DIV, 32'd10);
    fs = frames_started;
    for (int i = 0; i < 3; i++) bus_write(A_DATA, 32'($urandom_range(0, 255)));
    n = 0;
    while (frames_started == fs && n < 50) begin
      @(posedge clk);
      n++;
    end
    check("async_frame_started", (n < 50), 1'b1);
    repeat (36) @(posedge clk);
    #2;
    check("tx_low_before_reset", tx, 1'b0);
    rst_n = 1'b0;
    #1;
    check("async_reset_tx_high", tx, 1'b1);
    exp_q.delete();
    pushed         = 0;
    frames_started = 0;
    frames_done    = 0;
    model_ovf      = 1'b0;
    model_div      = 10;
    idle_cycles(3);
    rst_n = 1'b1;
    idle_cycles(2);
    bus_read(A_STAT, rd); check("after_reset_status", rd, 32'h08);
    bus_read(A_DIV, rd);  check("after_reset_div", rd, 32'd10);
    nlow = 0;
    repeat (300) begin
      @(negedge clk);
      if (tx !== 1'b1) nlow++;
    end
    check("no_frames_after_reset", nlow, 0);
    check("no_frames_started_after_reset", frames_started, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
Memory-mapped UART transmitter on the core's data-memory port, alongside data memory; it consumes the core's load/store bus (memory_read, memory_write, ALU address, rs2 store data).
Stores to its DATA register push bytes into a TX FIFO. A frame state machine serialises them as 8N1, LSB first, on tx.
Loads return status and the baud divisor combinationally, because the single-cycle core samples read data in the same cycle.

Parameters:
CLOCK_FREQ, 25000000, core clock in Hz
BAUD_RATE, 115200, reset baud; reset divisor = CLOCK_FREQ/BAUD_RATE (integer division)
FIFO_DEPTH, 8, TX FIFO entries; power of two, ≥2
BASE_ADDRESS, 32'h00001000, block base; 16-byte aligned

Ports:
clk  input  1  core clock, all state on rising edge
reset  input  1  asynchronous, active-low; 0 = in reset
memory_read  input  1  load strobe from control unit
memory_write  input  1  store strobe from control unit
address  input  32  byte address (ALU result)
write_data  input  32  store data (rs2)
read_data  output  32  load data, combinational
tx  output  1  serial line, idle high
irq  output  1  high while FIFO empty and state IDLE

Behaviour:
- Select: sel = (address[31:4] == BASE_ADDRESS[31:4]); offset = address[3:2]; address[1:0] ignored.
- Register map:
  - 0x0 DATA: write only. A store pushes write_data[7:0]. Reads return 0.
  - 0x4 STATUS: read returns {27'b0, overflow, fifo_empty, fifo_full, busy, 1'b0} as bits [4:0]: overflow = bit4, fifo_empty = bit3, fifo_full = bit2, busy = bit1, bit0 = 0. A write with write_data[4]=1 clears overflow; all other bits are ignored.
  - 0x8 DIV: 16-bit baud divisor in bits [15:0]. Read-write. Writes of 0 or 1 are stored as 2.
  - 0xC: reserved, reads 0, writes ignored.
- read_data = 0 unless sel && memory_read. It is purely combinational from the current state; a read has no side effects.
- Reset values: tx=1, state=IDLE, FIFO empty, count=0, overflow=0, DIV=CLOCK_FREQ/BAUD_RATE, bit counter=0, baud counter=0, irq=1, read_data=0.
- Push happens at the rising edge where sel && memory_write && offset==0.
  - FIFO full and no pop that edge: byte dropped, overflow set (sticky). If a pop occurs the same edge, the push is accepted and count is unchanged.
  - Clear and set of overflow on the same edge: set wins.
- FSM states IDLE, START, DATA, STOP. Every bit lasts exactly DIV clocks, counted by the baud counter from 0 to DIV-1.
  - IDLE: tx=1. If the FIFO is non-empty, pop the head into the shift register, latch DIV into the active divisor, and go to START.
  - START: tx=0 for DIV clocks, then DATA.
  - DATA: tx=shift[0]. Shift right after each bit; 8 bits, bit counter 0..7, then STOP.
  - STOP: tx=1 for DIV clocks. Then, if the FIFO is non-empty, pop, latch DIV and go directly to START with no idle gap; otherwise go to IDLE.
- busy = (state != IDLE).
- Timing:
  - Store at edge T into an empty FIFO while IDLE: pop at edge T+1, tx falls after T+1.
  - Frame length is 10×DIV clocks.
- DIV changes take effect only at the next pop. An in-flight frame keeps its latched divisor.
- FIFO: circular pointers of log2(FIFO_DEPTH) bits wrap modulo depth; count is log2(FIFO_DEPTH)+1 bits.
- Reset asserted mid-frame: tx returns to 1 immediately (asynchronously) and the FIFO contents are discarded.
- Stores to unselected addresses have no effect. Loads and stores in the same cycle are independent.

Test Plan:
- Setup: CLOCK_FREQ=1000000, BAUD_RATE=100000 (DIV=10).
- Reset: hold reset=0 → tx=1, irq=1, read STATUS(0x1004)=0x08, read DIV(0x1008)=10. Release; after 5 clocks, values unchanged.
- Single byte: store 0x55 to 0x1000 → tx low 10 clocks starting one edge after the store, then bits 1,0,1,0,1,0,1,0 at 10 clocks each, then stop high for 10 clocks. busy=1 during the 100-clock frame; irq=1 after it.
- Back-to-back: store 0xA5 and 0x3C on consecutive cycles → two frames 200 clocks total; second start bit begins the clock after the first stop bit ends.
- Overflow: with DEPTH=8, store 10 bytes in 10 consecutive cycles (first popped at edge 2) → 9 accepted, last dropped, STATUS bit4=1. Store 0x10 to 0x1004 → bit4=0. All 9 accepted bytes are transmitted in order.
- Divisor: write 0 to 0x1008 → reads back 2; next frame lasts 20 clocks. Write 20 mid-frame → current frame unchanged, following frame lasts 200 clocks.
- Async reset: assert reset=0 at clock 37 of a frame with 3 bytes queued → tx=1 with no clock edge needed. After release: STATUS=0x08 and no further frames are sent.
